// File: rtl/demux1x4_stripe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : demux1x4_stripe_pkg                                              |
// | Brief   : Shared PHY lane constants and un-striper FSM state encoding.     |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package demux1x4_stripe_pkg;

    localparam int LANES          = 4;
    localparam int IDX_W          = 2;
    localparam int DATA_WIDTH_DEF = 8;

    typedef enum logic {
        FILL  = 1'b0,
        STALL = 1'b1
    } state_t;

endpackage : demux1x4_stripe_pkg
`default_nettype wire

// File: rtl/demux1x4_stripe_stage_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : demux1x4_stripe_stage_bank                                       |
// | Brief   : Four-lane staging registers with write index and fill mask.      |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module demux1x4_stripe_stage_bank
    import demux1x4_stripe_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              wr_en_i,
    input  logic [DATA_WIDTH-1:0]             wr_data_i,
    input  logic                              clr_i,
    output logic [LANES-1:0][DATA_WIDTH-1:0]  stage_o,
    output logic [LANES-1:0]                  mask_o,
    output logic [IDX_W-1:0]                  idx_o
);

    logic [LANES-1:0][DATA_WIDTH-1:0] stage_q;
    logic [LANES-1:0]                 mask_q;
    logic [IDX_W-1:0]                 idx_q;

    // Clear wins over write: a byte arriving with clear was already merged
    // into the group that is leaving the bank.
    always_ff @(posedge clk) begin
        if (reset || clr_i) begin
            stage_q <= '0;
            mask_q  <= '0;
            idx_q   <= '0;
        end else if (wr_en_i) begin
            stage_q[idx_q] <= wr_data_i;
            mask_q[idx_q]  <= 1'b1;
            idx_q          <= idx_q + 1'b1;
        end
    end

    assign stage_o = stage_q;
    assign mask_o  = mask_q;
    assign idx_o   = idx_q;

endmodule : demux1x4_stripe_stage_bank
`default_nettype wire

// File: rtl/demux1x4_stripe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : demux1x4_stripe                                                  |
// | Brief   : Serial byte stream to four parallel lanes, round-robin striping. |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module demux1x4_stripe
    import demux1x4_stripe_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int LANES      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] out0,
    output logic [DATA_WIDTH-1:0] out1,
    output logic [DATA_WIDTH-1:0] out2,
    output logic [DATA_WIDTH-1:0] out3,
    output logic [3:0]            valid_out,
    input  logic                  out_ready,
    output logic                  err
);

    logic                             w_accept;
    logic                             w_pending;
    logic                             w_consume;
    logic                             w_complete;
    logic                             w_load;
    logic [LANES-1:0][DATA_WIDTH-1:0] w_stage;
    logic [LANES-1:0]                 w_mask;
    logic [IDX_W-1:0]                 w_idx;
    logic [LANES-1:0][DATA_WIDTH-1:0] w_grp_data;
    logic [LANES-1:0]                 w_grp_mask;

    state_t                           state_q;
    logic [LANES-1:0][DATA_WIDTH-1:0] out_q;
    logic [LANES-1:0]                 valid_q;
    logic                             err_q;

    demux1x4_stripe_stage_bank #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_stage_bank (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (w_accept),
        .wr_data_i (in_data),
        .clr_i     (w_load),
        .stage_o   (w_stage),
        .mask_o    (w_mask),
        .idx_o     (w_idx)
    );

    // Group view including the byte accepted this cycle, so a completion on
    // the fourth byte or a same-cycle flush loads with single-edge latency.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign w_grp_data[i] = (w_accept && (w_idx == IDX_W'(i))) ? in_data : w_stage[i];
        assign w_grp_mask[i] = w_mask[i] | (w_accept && (w_idx == IDX_W'(i)));
    end

    assign in_ready   = (state_q == FILL);
    assign w_accept   = in_valid && in_ready;
    assign w_pending  = (valid_q != '0);
    assign w_consume  = w_pending && out_ready;
    assign w_complete = (state_q == FILL) &&
                        ((w_accept && (w_idx == IDX_W'(LANES - 1))) ||
                         (flush && (w_grp_mask != '0)));
    assign w_load     = (w_complete && (!w_pending || w_consume)) ||
                        ((state_q == STALL) && w_consume);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FILL;
            out_q   <= '0;
            valid_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (in_valid && !in_ready) begin
                err_q <= 1'b1;
            end

            if (w_load) begin
                for (int i = 0; i < LANES; i++) begin
                    out_q[i] <= w_grp_mask[i] ? w_grp_data[i] : '0;
                end
                valid_q <= w_grp_mask;
            end else if (w_consume) begin
                valid_q <= '0;
            end

            case (state_q)
                FILL:    if (w_complete && !w_load) state_q <= STALL;
                STALL:   if (w_consume)             state_q <= FILL;
                default:                            state_q <= FILL;
            endcase
        end
    end

    assign out0      = out_q[0];
    assign out1      = out_q[1];
    assign out2      = out_q[2];
    assign out3      = out_q[3];
    assign valid_out = valid_q;
    assign err       = err_q;

endmodule : demux1x4_stripe
`default_nettype wire

// File: tb/tb_demux1x4_stripe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_demux1x4_stripe                                               |
// | Brief   : Scoreboard bench for the four-lane byte un-striper.              |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_demux1x4_stripe;

    logic       clk;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       flush;
    logic [7:0] out0, out1, out2, out3;
    logic [3:0] valid_out;
    logic       out_ready;
    logic       err;

    int total = 0;
    int bad   = 0;

    // Expected group: {lane3, lane2, lane1, lane0, mask}
    logic [35:0] sb_q[$];

    demux1x4_stripe #(
        .DATA_WIDTH (8),
        .LANES      (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .out0      (out0),
        .out1      (out1),
        .out2      (out2),
        .out3      (out3),
        .valid_out (valid_out),
        .out_ready (out_ready),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A group leaves the DUT when it is presented and accepted at the next edge.
    always @(negedge clk) begin
        if (!reset && valid_out != 4'b0000 && out_ready) begin
            logic [35:0] exp_v;
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: got lanes=%h_%h_%h_%h mask=%b, expected no group",
                         out3, out2, out1, out0, valid_out);
            end else begin
                exp_v = sb_q.pop_front();
                if ({out3, out2, out1, out0, valid_out} !== exp_v) begin
                    bad++;
                    $display("FAIL sb_group: got lanes=%h_%h_%h_%h mask=%b, expected lanes=%h mask=%b",
                             out3, out2, out1, out0, valid_out, exp_v[35:4], exp_v[3:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic f);
        in_data  = b;
        in_valid = 1'b1;
        flush    = f;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        total++;
        if ({out3, out2, out1, out0, valid_out, err} !== 37'd0) begin
            bad++;
            $display("FAIL reset_outputs: got lanes=%h_%h_%h_%h mask=%b err=%b, expected all zero",
                     out3, out2, out1, out0, valid_out, err);
        end
        reset = 1'b0;
        tick();
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_full_group();
        logic [7:0] bytes [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        out_ready = 1'b1;
        sb_q.push_back({8'hD4, 8'hC3, 8'hB2, 8'hA1, 4'b1111});
        for (int i = 0; i < 4; i++) begin
            total++;
            if (in_ready !== 1'b1) begin
                bad++;
                $display("FAIL full_in_ready: byte %0d got %b expected 1", i, in_ready);
            end
            send(bytes[i], 1'b0);
        end
        total++;
        if (valid_out !== 4'b1111 || out0 !== 8'hA1 || out3 !== 8'hD4) begin
            bad++;
            $display("FAIL full_latency: got mask=%b out0=%h out3=%h expected 1111 a1 d4",
                     valid_out, out0, out3);
        end
        tick();
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        sb_q.push_back({8'h00, 8'h00, 8'h22, 8'h11, 4'b0011});
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        total++;
        if (valid_out !== 4'b0011 || out2 !== 8'h00 || out3 !== 8'h00) begin
            bad++;
            $display("FAIL flush_partial: got mask=%b out2=%h out3=%h expected 0011 00 00",
                     valid_out, out2, out3);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        total++;
        if (valid_out !== 4'b0000) begin
            bad++;
            $display("FAIL flush_empty: got mask=%b expected 0000", valid_out);
        end
        sb_q.push_back({8'h00, 8'h00, 8'h00, 8'h33, 4'b0001});
        send(8'h33, 1'b1);
        tick();
    endtask

    task automatic test_stall_and_err();
        out_ready = 1'b0;
        sb_q.push_back({8'h04, 8'h03, 8'h02, 8'h01, 4'b1111});
        sb_q.push_back({8'h08, 8'h07, 8'h06, 8'h05, 4'b1111});
        for (int i = 1; i <= 8; i++) send(8'(i), 1'b0);
        total++;
        if (in_ready !== 1'b0 || valid_out !== 4'b1111 || out0 !== 8'h01) begin
            bad++;
            $display("FAIL stall_enter: got in_ready=%b mask=%b out0=%h expected 0 1111 01",
                     in_ready, valid_out, out0);
        end
        in_data  = 8'h5A;
        in_valid = 1'b1;
        flush    = 1'b1;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        total++;
        if (err !== 1'b1 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL stall_err: got err=%b in_ready=%b expected 1 0", err, in_ready);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++;
        if (in_ready !== 1'b1 || valid_out !== 4'b1111 || out0 !== 8'h05) begin
            bad++;
            $display("FAIL stall_release: got in_ready=%b mask=%b out0=%h expected 1 1111 05",
                     in_ready, valid_out, out0);
        end
        tick();
        tick();
        total++;
        if (valid_out !== 4'b1111 || out3 !== 8'h08 || err !== 1'b1) begin
            bad++;
            $display("FAIL stall_hold: got mask=%b out3=%h err=%b expected 1111 08 1",
                     valid_out, out3, err);
        end
        out_ready = 1'b1;
        tick();
        total++;
        if (valid_out !== 4'b0000) begin
            bad++;
            $display("FAIL consume_clear: got mask=%b expected 0000", valid_out);
        end
    endtask

    task automatic test_reset_mid_group();
        out_ready = 1'b1;
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if (err !== 1'b0 || valid_out !== 4'b0000 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL midreset_state: got err=%b mask=%b in_ready=%b expected 0 0000 1",
                     err, valid_out, in_ready);
        end
        sb_q.push_back({8'h0D, 8'h0C, 8'h0B, 8'h0A, 4'b1111});
        send(8'h0A, 1'b0);
        send(8'h0B, 1'b0);
        send(8'h0C, 1'b0);
        send(8'h0D, 1'b0);
        tick();
        tick();
    endtask

    task automatic test_flush_on_last();
        out_ready = 1'b1;
        sb_q.push_back({8'h44, 8'h43, 8'h42, 8'h41, 4'b1111});
        send(8'h41, 1'b0);
        send(8'h42, 1'b0);
        send(8'h43, 1'b0);
        send(8'h44, 1'b1);
        total++;
        if (valid_out !== 4'b1111 || out3 !== 8'h44) begin
            bad++;
            $display("FAIL flush_last_full: got mask=%b out3=%h expected 1111 44", valid_out, out3);
        end
        tick();
        total++;
        if (valid_out !== 4'b0000) begin
            bad++;
            $display("FAIL flush_last_extra: got mask=%b expected 0000", valid_out);
        end
        sb_q.push_back({8'h00, 8'h00, 8'h00, 8'h55, 4'b0001});
        send(8'h55, 1'b1);
        tick();
        tick();
    endtask

    initial begin
        reset     = 1'b1;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_full_group();
        test_flush();
        test_stall_and_err();
        test_reset_mid_group();
        test_flush_on_last();
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: got %0d groups outstanding expected 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_demux1x4_stripe
`default_nettype wire
